tdc_hw_reader: RTL and testbench
================================

Name: tdc_hw_reader

Overview:
- Consumer end of the TDC measurement path: commands a launch edge and waits out the capture/pop-count latency.
- Reads the Hamming-weight result hw, repeats for 2^N_AVG_LOG2 samples, then presents sum, mean, min and max on a valid/ready result port.
- Sits beside the TDC top on clk_capture: drives its pg_tog and consumes its hw output.

Parameters:
- HW_W, 7, width of hw input (clog2(delay-line taps)+1; 7 for 64 taps).
- N_AVG_LOG2, 4, log2 of samples per measurement (16 samples).
- LAT, 3, clk_capture cycles from pg_tog assertion until hw reflects that launch; legal range 1..15.

Ports:
- clk_capture  in  1  capture clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global enable; when low, all state holds (FSM, counters, accumulators, outputs).
- start  in  1  one-cycle request to begin a measurement; honoured only in IDLE.
- hw  in  HW_W  Hamming weight from the TDC pop-count.
- pg_tog  out  1  launch request to the pulse generator; one-cycle pulse per sample.
- busy  out  1  high in every state except IDLE.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_sum  out  HW_W+N_AVG_LOG2  sum of all samples.
- res_mean  out  HW_W  res_sum >> N_AVG_LOG2 (truncating).
- res_min  out  HW_W  smallest sample.
- res_max  out  HW_W  largest sample.

Behaviour:
- Reset (rst=1 at a clock edge, regardless of en or state):
  - state=IDLE; pg_tog=0, busy=0, res_valid=0.
  - res_sum, res_mean, res_min, res_max all 0; sample counter 0; wait counter 0.
- en=0: no state change of any kind. pg_tog is forced 0 while en=0. A start arriving while en=0 is lost.
- States:
  - IDLE: start=1 -> TRIG; clear accumulator and sample count; min register := all-ones, max register := 0.
  - TRIG: pg_tog=1 for exactly this cycle; load wait counter with LAT-1 -> WAIT.
  - WAIT: decrement wait counter; at 0 -> SAMPLE.
  - SAMPLE:
    - Add zero-extended hw to the accumulator; update min/max; increment sample count.
    - If the count reaches 2^N_AVG_LOG2 -> DONE and latch the result registers.
    - Otherwise -> TRIG.
  - DONE: res_valid=1; results stable. res_valid and res_ready both 1 -> IDLE with res_valid=0 on the next cycle.
- Timing:
  - One sample takes LAT+2 cycles.
  - A full measurement takes 2^N_AVG_LOG2*(LAT+2) cycles from the start edge to res_valid rising.
  - hw is sampled in the cycle LAT+1 clocks after TRIG.
- Arithmetic:
  - The accumulator is HW_W+N_AVG_LOG2 bits and cannot overflow (max 2^HW_W-1 per sample).
  - res_mean is the truncated upper HW_W bits of the sum.
  - Min/max comparisons are unsigned.
- Boundary cases:
  - start while busy: ignored.
  - start in the same cycle res_valid/res_ready completes: ignored, because the FSM is not yet in IDLE.
  - res_ready held 1 before DONE: the result is accepted in the first DONE cycle (res_valid high exactly one cycle).
  - Result registers keep the last accepted values in IDLE until the next measurement completes. Exception: reset clears them.
  - rst asserted mid-measurement: abort to IDLE; no partial result is produced.

Optional Feature:
- Macro TDC_READER_MINMAX_EN.
- Defined: min/max tracking as above.
- Undefined: min/max registers and comparators are not synthesized; res_min and res_max are tied to 0. All other behaviour and timing are identical.

Test Plan:
1. Reset, then start with hw held at 40, LAT=3 -> pg_tog pulses 16 times, every 5 cycles; res_valid rises 80 cycles after start. Expected res_sum=640, res_mean=40, res_min=40, res_max=40.
2. hw model returning 30,31,...,45 for successive launches (tracking pg_tog+LAT) -> res_sum=600, res_mean=37, res_min=30, res_max=45.
3. Second start pulse at cycle 10 of a measurement; also start in the same cycle as the accepting handshake -> both ignored; exactly 16 pg_tog pulses.
4. In DONE, res_ready held 0 for 20 cycles -> res_valid and all result values stable; res_ready=1 -> res_valid=0 and busy=0 on the next cycle.
5. en=0 for 7 cycles mid-WAIT -> no pg_tog, no state advance; total latency increases by exactly 7 cycles and the sum is unchanged.
6. rst pulsed after 8 samples -> all outputs 0 and IDLE next cycle; a new start yields a correct full 16-sample result. Build without TDC_READER_MINMAX_EN -> res_min=res_max=0 and the sum/mean from scenario 2 are unchanged.

Source files
------------

// File: rtl/tdc_hw_reader.sv
// TDC consumer: launches 2^N_AVG_LOG2 pulse-generator edges, accumulates the pop-count
// results and offers sum/mean/min/max on a valid/ready port. Min/max tracking is built
// only when TDC_READER_MINMAX_EN is defined; otherwise res_min/res_max read 0.
module tdc_hw_reader #(
    parameter int HW_W       = 7,
    parameter int N_AVG_LOG2 = 4,
    parameter int LAT        = 3
) (
    input  logic                       clk_capture,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       start,
    input  logic [HW_W-1:0]            hw,
    output logic                       pg_tog,
    output logic                       busy,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [HW_W+N_AVG_LOG2-1:0] res_sum,
    output logic [HW_W-1:0]            res_mean,
    output logic [HW_W-1:0]            res_min,
    output logic [HW_W-1:0]            res_max,
    output logic [2:0]                 fsm_state
);
    localparam int SUM_W = HW_W + N_AVG_LOG2;
    localparam int CNT_W = N_AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << N_AVG_LOG2) - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_TRIG   = 3'd1,
        S_WAIT   = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t           state;
    logic             pg_r;
    logic [3:0]       wait_cnt;
    logic [CNT_W-1:0] sample_cnt;
    logic [SUM_W-1:0] acc;
    logic [SUM_W-1:0] sum_next;
    logic             last_sample;

    assign sum_next    = acc + SUM_W'(hw);
    assign last_sample = (sample_cnt == LAST_CNT);

    // Result handshake: res_valid holds with stable data until res_valid && res_ready
    // are both high at a clock edge; the FSM then returns to IDLE.
    assign pg_tog    = pg_r & en;
    assign busy      = (state != S_IDLE);
    assign res_valid = (state == S_DONE);
    assign fsm_state = state;

    always_ff @(posedge clk_capture) begin
        if (rst) begin
            state      <= S_IDLE;
            pg_r       <= 1'b0;
            wait_cnt   <= '0;
            sample_cnt <= '0;
            acc        <= '0;
            res_sum    <= '0;
            res_mean   <= '0;
        end else if (en) begin
            pg_r <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_TRIG;
                        pg_r       <= 1'b1;
                        acc        <= '0;
                        sample_cnt <= '0;
                    end
                end
                S_TRIG: begin
                    wait_cnt <= 4'(LAT - 1);
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == 4'd0) state <= S_SAMPLE;
                    else                  wait_cnt <= wait_cnt - 4'd1;
                end
                S_SAMPLE: begin
                    acc        <= sum_next;
                    sample_cnt <= sample_cnt + 1'b1;
                    if (last_sample) begin
                        state    <= S_DONE;
                        res_sum  <= sum_next;
                        res_mean <= sum_next[SUM_W-1:N_AVG_LOG2];
                    end else begin
                        state <= S_TRIG;
                        pg_r  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (res_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef TDC_READER_MINMAX_EN
    logic [HW_W-1:0] min_r;
    logic [HW_W-1:0] max_r;
    logic [HW_W-1:0] min_next;
    logic [HW_W-1:0] max_next;

    assign min_next = (hw < min_r) ? hw : min_r;
    assign max_next = (hw > max_r) ? hw : max_r;

    always_ff @(posedge clk_capture) begin
        if (rst) begin
            min_r   <= '0;
            max_r   <= '0;
            res_min <= '0;
            res_max <= '0;
        end else if (en) begin
            if (state == S_IDLE && start) begin
                min_r <= '1;
                max_r <= '0;
            end else if (state == S_SAMPLE) begin
                min_r <= min_next;
                max_r <= max_next;
                if (last_sample) begin
                    res_min <= min_next;
                    res_max <= max_next;
                end
            end
        end
    end
`else
    assign res_min = '0;
    assign res_max = '0;
`endif

endmodule

// File: tb/tb_tdc_hw_reader.sv
// Bench for tdc_hw_reader: a TDC stand-in answers each launch, a cycle-level model
// derived from the sample/measurement timing predicts every output on each cycle.
module tb_tdc_hw_reader;
    localparam int HW_W = 7;
    localparam int NL2  = 4;
    localparam int LAT  = 3;
    localparam int NS   = 1 << NL2;
    localparam int SP   = LAT + 2;
    localparam int MEAS = NS * SP;
`ifdef TDC_READER_MINMAX_EN
    localparam bit MM = 1'b1;
`else
    localparam bit MM = 1'b0;
`endif

    logic                 clk_capture;
    logic                 rst, en, start, res_ready;
    logic [HW_W-1:0]      hw;
    logic                 pg_tog, busy, res_valid;
    logic [HW_W+NL2-1:0]  res_sum;
    logic [HW_W-1:0]      res_mean, res_min, res_max;
    logic [2:0]           fsm_state;

    tdc_hw_reader #(.HW_W(HW_W), .N_AVG_LOG2(NL2), .LAT(LAT)) dut (
        .clk_capture(clk_capture), .rst(rst), .en(en), .start(start), .hw(hw),
        .pg_tog(pg_tog), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_mean(res_mean), .res_min(res_min), .res_max(res_max),
        .fsm_state(fsm_state)
    );

    // clock / cycle counter
    initial clk_capture = 1'b0;
    always #5 clk_capture = ~clk_capture;
    int cyc = 0;
    always @(posedge clk_capture) cyc++;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // TDC stand-in: after a launch, hw shows a wrong value until the cycle the sample is due
    logic [HW_W-1:0] vals[NS];
    int launch_idx = 0;
    int cur_idx = 0;
    int cd = 0;
    initial hw = '0;
    always @(negedge clk_capture) begin
        if (cd > 0) begin
            cd--;
            if (cd == 0) hw = vals[cur_idx % NS];
        end
        if (pg_tog === 1'b1) begin
            cur_idx = launch_idx;
            launch_idx++;
            hw = ~vals[cur_idx % NS];
            cd = LAT + 1;
        end
    end

    // model: m_k counts enabled cycles since the accepted start edge
    bit              m_active = 1'b0;
    int              m_k = 0;
    logic [HW_W+NL2-1:0] e_sum = '0;
    logic [HW_W-1:0] e_mean = '0, e_min = '0, e_max = '0;

    always @(posedge clk_capture) begin
        if (rst) begin
            m_active = 1'b0; m_k = 0;
            e_sum = '0; e_mean = '0; e_min = '0; e_max = '0;
        end else if (en) begin
            if (!m_active) begin
                if (start) begin
                    m_active = 1'b1; m_k = 0; launch_idx = 0;
                end
            end else if (m_k < MEAS) begin
                m_k++;
                if (m_k == MEAS) begin
                    int s, mn, mx;
                    s = 0; mn = (1 << HW_W) - 1; mx = 0;
                    for (int i = 0; i < NS; i++) begin
                        s += int'(vals[i]);
                        if (int'(vals[i]) < mn) mn = int'(vals[i]);
                        if (int'(vals[i]) > mx) mx = int'(vals[i]);
                    end
                    e_sum  = (HW_W+NL2)'(s);
                    e_mean = HW_W'(s / NS);
                    e_min  = MM ? HW_W'(mn) : '0;
                    e_max  = MM ? HW_W'(mx) : '0;
                end
            end else if (res_ready) begin
                m_active = 1'b0;
            end
        end
    end

    // per-cycle compare
    always @(negedge clk_capture) begin
        if (chk_on) begin
            check("pg_tog", pg_tog, m_active && en && m_k < MEAS && (m_k % SP) == 0);
            check("busy", busy, m_active);
            check("res_valid", res_valid, m_active && m_k >= MEAS);
            check("res_sum", res_sum, e_sum);
            check("res_mean", res_mean, e_mean);
            check("res_min", res_min, e_min);
            check("res_max", res_max, e_max);
        end
    end

    // driver tasks
    int t0;
    task automatic fill_const(input int v);
        for (int i = 0; i < NS; i++) vals[i] = HW_W'(v);
    endtask

    task automatic do_start();
        @(posedge clk_capture); #1 start = 1'b1;
        @(posedge clk_capture); #1 start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_valid(output int lat);
        int n;
        n = 0;
        lat = -1;
        while (n < 2000) begin
            @(negedge clk_capture);
            if (res_valid === 1'b1) begin
                lat = cyc - t0;
                break;
            end
            n++;
        end
        if (lat < 0) check("timeout_res_valid", 0, 1);
    endtask

    task automatic accept();
        res_ready = 1'b1;
        @(posedge clk_capture); #1 res_ready = 1'b0;
        @(negedge clk_capture);
        check("accept_busy", busy, 0);
        check("accept_valid", res_valid, 0);
    endtask

    task automatic check_res(input string tag, input int s, input int m, input int mn, input int mx);
        check({tag, "_sum"}, res_sum, s);
        check({tag, "_mean"}, res_mean, m);
        check({tag, "_min"}, res_min, MM ? mn : 0);
        check({tag, "_max"}, res_max, MM ? mx : 0);
    endtask

    int lat;

    initial begin
        rst = 1'b1; en = 1'b1; start = 1'b0; res_ready = 1'b0;
        fill_const(0);
        repeat (3) @(posedge clk_capture);
        #1 rst = 1'b0; chk_on = 1'b1;
        @(negedge clk_capture);
        check("reset_busy", busy, 0);
        check("reset_pg", pg_tog, 0);
        check_res("reset", 0, 0, 0, 0);

        // constant hw
        fill_const(40);
        do_start();
        wait_valid(lat);
        check("s1_latency", lat, MEAS);
        check("s1_pulses", launch_idx, NS);
        check_res("s1", 640, 40, 40, 40);
        accept();

        // ramp 30..45, ready held high before DONE
        for (int i = 0; i < NS; i++) vals[i] = HW_W'(30 + i);
        res_ready = 1'b1;
        do_start();
        wait_valid(lat);
        check("s2_latency", lat, MEAS);
        check_res("s2", 600, 37, 30, 45);
        @(negedge clk_capture);
        check("s2_one_cycle_valid", res_valid, 0);
        res_ready = 1'b0;

        // starts while busy and during the accepting handshake
        for (int i = 0; i < NS; i++) vals[i] = HW_W'($urandom_range(0, 127));
        do_start();
        repeat (9) @(posedge clk_capture);
        #1 start = 1'b1;
        @(posedge clk_capture); #1 start = 1'b0;
        wait_valid(lat);
        check("s3_pulses", launch_idx, NS);
        res_ready = 1'b1; start = 1'b1;
        @(posedge clk_capture); #1 res_ready = 1'b0; start = 1'b0;
        repeat (10) @(negedge clk_capture);
        check("s3_no_restart", launch_idx, NS);
        check("s3_idle", busy, 0);

        // DONE held with ready low
        for (int i = 0; i < NS; i++) vals[i] = HW_W'(7 * i);
        do_start();
        wait_valid(lat);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_capture);
            check("s4_hold_valid", res_valid, 1);
            check_res("s4", 840, 52, 0, 105);
        end
        accept();

        // enable dropped for 7 cycles during WAIT
        fill_const(40);
        do_start();
        @(posedge clk_capture); #1 en = 1'b0;
        repeat (7) @(posedge clk_capture);
        #1 en = 1'b1;
        wait_valid(lat);
        check("s5_latency", lat, MEAS + 7);
        check_res("s5", 640, 40, 40, 40);
        accept();

        // reset after 8 samples, then a clean run
        for (int i = 0; i < NS; i++) vals[i] = HW_W'($urandom_range(0, 127));
        do_start();
        repeat (8 * SP) @(posedge clk_capture);
        #1 rst = 1'b1;
        @(posedge clk_capture); #1 rst = 1'b0;
        @(negedge clk_capture);
        check("s6_busy", busy, 0);
        check("s6_valid", res_valid, 0);
        check_res("s6_rst", 0, 0, 0, 0);
        fill_const(20);
        do_start();
        wait_valid(lat);
        check("s6_latency", lat, MEAS);
        check_res("s6", 320, 20, 20, 20);
        accept();

        // random traffic
        for (int c = 0; c < 2500; c++) begin
            @(posedge clk_capture); #1;
            if (!m_active)
                for (int i = 0; i < NS; i++) vals[i] = HW_W'($urandom_range(0, 127));
            en        = ($urandom_range(0, 9) != 0);
            start     = ($urandom_range(0, 5) == 0);
            res_ready = ($urandom_range(0, 3) == 0);
            rst       = ($urandom_range(0, 399) == 0);
        end
        @(posedge clk_capture); #1;
        en = 1'b1; start = 1'b0; res_ready = 1'b1; rst = 1'b0;
        repeat (2 * MEAS) @(posedge clk_capture);
        @(negedge clk_capture);
        check("drain_idle", busy, 0);
        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
